// File: rtl/player_pkg.sv
// Shared types and limits for the player engine/gearbox model.
package player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SHIFT = 2'd2,
    BLOWN = 2'd3
  } engine_state_e;

  localparam logic [2:0] GEAR_MAX   = 3'd5;
  localparam logic [7:0] RPM_MAX    = 8'd255;
  localparam logic [7:0] PERFECT_LO = 8'd200;
  localparam logic [7:0] PERFECT_HI = 8'd239;
  localparam logic [4:0] D_POS_MAX  = 5'd31;

  // Distance per tick: ((rpm>>4)*gear)>>1, saturated to D_POS_MAX.
  function automatic logic [4:0] calc_d_pos(input logic [7:0] rpm_v, input logic [2:0] gear_v);
    logic [6:0] prod;
    prod = 7'(rpm_v[7:4]) * 7'(gear_v);
    if (prod[6:1] > 6'(D_POS_MAX)) return D_POS_MAX;
    return prod[5:1];
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Divides clk down to a single-cycle enable pulse every TICK_DIV cycles.
module tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/player2_engine.sv
// Player 2 engine/gearbox: RPM, gear, timed shifts and redline blow-up on a tick enable.
// Optional PERFECT_SHIFT_EN adds the perfect-upshift bonus and the `perfect` output.
module player2_engine
  import player_pkg::*;
#(
  parameter int TICK_DIV      = 1000000,
  parameter int RPM_UP        = 4,
  parameter int RPM_DOWN      = 2,
  parameter int IDLE_RPM      = 16,
  parameter int SHIFT_TICKS   = 10,
  parameter int REDLINE_TICKS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       race_active,
  input  logic       gas,
  input  logic       gear_up,
  input  logic       gear_down,
  output logic [4:0] d_position,
  output logic [2:0] gear,
  output logic [7:0] rpm,
  output logic       shifting,
  output logic       blown
`ifdef PERFECT_SHIFT_EN
  ,
  output logic       perfect
`endif
);
  localparam int SCW = $clog2(SHIFT_TICKS + 1);
  localparam int RDW = $clog2(REDLINE_TICKS + 1);
  localparam logic [SCW-1:0] SHIFT_LAST = SCW'(SHIFT_TICKS - 1);
  localparam logic [RDW-1:0] RED_LIMIT  = RDW'(REDLINE_TICKS);

  logic tick;
  engine_state_e state_q, state_d;
  logic [7:0] rpm_q, rpm_d;
  logic [2:0] gear_q, gear_d;
  logic [SCW-1:0] shift_cnt_q, shift_cnt_d;
  logic [RDW-1:0] redline_q, redline_d;
  logic dir_up_q, dir_up_d;
  logic up_prev_q, dn_prev_q;
  logic up_pend_q, up_pend_d, dn_pend_q, dn_pend_d;
  logic [4:0] d_pos_q, d_pos_d;
  logic req_up, req_dn, shift_ok;
  logic [7:0] rpm_rev, rpm_decay;
`ifdef PERFECT_SHIFT_EN
  logic perfect_flag_q, perfect_flag_d, perfect_q, perfect_d;
`endif

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  function automatic logic [7:0] rpm_rule(input logic [7:0] r, input logic throttle);
    logic [8:0] s;
    if (throttle) begin
      s = {1'b0, r} + 9'(RPM_UP);
      if (s > 9'(RPM_MAX)) s = 9'(RPM_MAX);
    end else if ({1'b0, r} < 9'(IDLE_RPM + RPM_DOWN)) begin
      s = 9'(IDLE_RPM);
    end else begin
      s = {1'b0, r} - 9'(RPM_DOWN);
    end
    if (s < 9'(IDLE_RPM)) s = 9'(IDLE_RPM);
    return s[7:0];
  endfunction

  // An edge arriving on the tick cycle itself still counts toward that tick.
  assign req_up    = up_pend_q | (gear_up & ~up_prev_q);
  assign req_dn    = dn_pend_q | (gear_down & ~dn_prev_q);
  assign up_pend_d = tick ? 1'b0 : req_up;
  assign dn_pend_d = tick ? 1'b0 : req_dn;
  assign shift_ok  = (req_up ^ req_dn) &&
                     ((req_up && gear_q < GEAR_MAX) || (req_dn && gear_q > 3'd1));
  assign rpm_rev   = rpm_rule(rpm_q, gas);
  assign rpm_decay = rpm_rule(rpm_q, 1'b0);

  always_comb begin
    state_d     = state_q;
    rpm_d       = rpm_q;
    gear_d      = gear_q;
    shift_cnt_d = shift_cnt_q;
    redline_d   = redline_q;
    dir_up_d    = dir_up_q;
`ifdef PERFECT_SHIFT_EN
    perfect_flag_d = perfect_flag_q;
    perfect_d      = 1'b0;
`endif
    if (tick) begin
      if (!race_active) begin
        state_d     = IDLE;
        gear_d      = '0;
        rpm_d       = rpm_rev;
        redline_d   = '0;
        shift_cnt_d = '0;
`ifdef PERFECT_SHIFT_EN
        perfect_flag_d = 1'b0;
`endif
      end else begin
        unique case (state_q)
          IDLE: begin
            state_d   = RUN;
            gear_d    = 3'd1;
            rpm_d     = rpm_rev;
            redline_d = '0;
          end
          RUN: begin
            if (shift_ok) begin
              state_d     = SHIFT;
              dir_up_d    = req_up;
              shift_cnt_d = '0;
              redline_d   = '0;
`ifdef PERFECT_SHIFT_EN
              perfect_flag_d = req_up && rpm_q >= PERFECT_LO && rpm_q <= PERFECT_HI;
`endif
            end else begin
              rpm_d = rpm_rev;
              if (rpm_rev != RPM_MAX) begin
                redline_d = '0;
              end else if (redline_q + RDW'(1) == RED_LIMIT) begin
                state_d   = BLOWN;
                rpm_d     = '0;
                gear_d    = '0;
                redline_d = '0;
              end else begin
                redline_d = redline_q + RDW'(1);
              end
            end
          end
          SHIFT: begin
            rpm_d       = rpm_decay;
            shift_cnt_d = shift_cnt_q + SCW'(1);
            if (shift_cnt_q == SHIFT_LAST) begin
              shift_cnt_d = '0;
              state_d     = RUN;
              if (dir_up_q) begin
                gear_d = gear_q + 3'd1;
                rpm_d  = {1'b0, rpm_decay[7:1]};
`ifdef PERFECT_SHIFT_EN
                if (perfect_flag_q) begin
                  rpm_d     = {1'b0, rpm_decay[7:1]} + 8'd32;
                  perfect_d = 1'b1;
                end
                perfect_flag_d = 1'b0;
`endif
              end else if (rpm_decay >= 8'd128) begin
                state_d = BLOWN;
                rpm_d   = '0;
                gear_d  = '0;
              end else begin
                gear_d = gear_q - 3'd1;
                rpm_d  = {rpm_decay[6:0], 1'b0};
              end
            end
          end
          BLOWN: begin
            rpm_d  = '0;
            gear_d = '0;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    shifting = (state_q == SHIFT);
    blown    = (state_q == BLOWN);
    d_pos_d  = (state_q == RUN) ? calc_d_pos(rpm_q, gear_q) : 5'd0;
  end

  assign d_position = d_pos_q;
  assign gear       = gear_q;
  assign rpm        = rpm_q;
`ifdef PERFECT_SHIFT_EN
  assign perfect    = perfect_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rpm_q       <= '0;
      gear_q      <= '0;
      shift_cnt_q <= '0;
      redline_q   <= '0;
      dir_up_q    <= 1'b0;
      up_prev_q   <= 1'b0;
      dn_prev_q   <= 1'b0;
      up_pend_q   <= 1'b0;
      dn_pend_q   <= 1'b0;
      d_pos_q     <= '0;
`ifdef PERFECT_SHIFT_EN
      perfect_flag_q <= 1'b0;
      perfect_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rpm_q       <= rpm_d;
      gear_q      <= gear_d;
      shift_cnt_q <= shift_cnt_d;
      redline_q   <= redline_d;
      dir_up_q    <= dir_up_d;
      up_prev_q   <= gear_up;
      dn_prev_q   <= gear_down;
      up_pend_q   <= up_pend_d;
      dn_pend_q   <= dn_pend_d;
      d_pos_q     <= d_pos_d;
`ifdef PERFECT_SHIFT_EN
      perfect_flag_q <= perfect_flag_d;
      perfect_q      <= perfect_d;
`endif
    end
  end
endmodule

// File: tb/tb_player2_engine.sv
// Self-checking bench for player2_engine: directed scenarios plus random stimulus vs a behavioural model.
module tb_player2_engine;
  localparam int TD = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_SHIFT = 2, S_BLOWN = 3;
`ifdef PERFECT_SHIFT_EN
  localparam bit PERFECT_BUILD = 1'b1;
`else
  localparam bit PERFECT_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, race_active, gas, gear_up, gear_down;
  logic [4:0] d_position;
  logic [2:0] gear;
  logic [7:0] rpm;
  logic shifting, blown;
`ifdef PERFECT_SHIFT_EN
  logic perfect;
`endif

  player2_engine #(.TICK_DIV(TD)) dut (
    .clk         (clk),
    .rst         (rst),
    .race_active (race_active),
    .gas         (gas),
    .gear_up     (gear_up),
    .gear_down   (gear_down),
    .d_position  (d_position),
    .gear        (gear),
    .rpm         (rpm),
    .shifting    (shifting),
    .blown       (blown)
`ifdef PERFECT_SHIFT_EN
    ,
    .perfect     (perfect)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_cnt, m_state, m_rpm, m_gear, m_shleft, m_redline, m_dpos;
  bit m_dir_up, m_pflag, m_perfect, m_up_prev, m_dn_prev, m_up_pend, m_dn_pend;

  task automatic expect_val(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rev(input int r, input bit throttle);
    int n;
    n = throttle ? r + 4 : r - 2;
    if (n > 255) n = 255;
    if (n < 16) n = 16;
    return n;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_state = S_IDLE; m_rpm = 0; m_gear = 0; m_shleft = 0; m_redline = 0;
    m_dpos = 0; m_dir_up = 0; m_pflag = 0; m_perfect = 0;
    m_up_prev = 0; m_dn_prev = 0; m_up_pend = 0; m_dn_pend = 0;
  endtask

  task automatic model_edge();
    bit tk, rq_up, rq_dn;
    int dpos_new;
    tk = (m_cnt == TD - 1);
    m_cnt = tk ? 0 : m_cnt + 1;
    dpos_new = 0;
    if (m_state == S_RUN) begin
      dpos_new = ((m_rpm / 16) * m_gear) / 2;
      if (dpos_new > 31) dpos_new = 31;
    end
    rq_up = m_up_pend || (gear_up && !m_up_prev);
    rq_dn = m_dn_pend || (gear_down && !m_dn_prev);
    m_up_prev = gear_up;
    m_dn_prev = gear_down;
    m_perfect = 0;
    if (!tk) begin
      m_up_pend = rq_up;
      m_dn_pend = rq_dn;
    end else begin
      m_up_pend = 0;
      m_dn_pend = 0;
      if (!race_active) begin
        m_state = S_IDLE; m_gear = 0; m_rpm = rev(m_rpm, gas); m_redline = 0; m_pflag = 0;
      end else if (m_state == S_IDLE) begin
        m_rpm = rev(m_rpm, gas); m_state = S_RUN; m_gear = 1;
      end else if (m_state == S_RUN) begin
        if (rq_up != rq_dn && ((rq_up && m_gear < 5) || (rq_dn && m_gear > 1))) begin
          m_state = S_SHIFT; m_dir_up = rq_up; m_shleft = 10; m_redline = 0;
          m_pflag = rq_up && m_rpm >= 200 && m_rpm <= 239;
        end else begin
          m_rpm = rev(m_rpm, gas);
          m_redline = (m_rpm == 255) ? m_redline + 1 : 0;
          if (m_redline == 50) begin
            m_state = S_BLOWN; m_rpm = 0; m_gear = 0; m_redline = 0;
          end
        end
      end else if (m_state == S_SHIFT) begin
        m_rpm = rev(m_rpm, 1'b0);
        m_shleft--;
        if (m_shleft == 0) begin
          if (m_dir_up) begin
            m_state = S_RUN; m_gear++;
            if (PERFECT_BUILD && m_pflag) begin
              m_rpm = m_rpm / 2 + 32; m_perfect = 1;
            end else begin
              m_rpm = m_rpm / 2;
            end
            m_pflag = 0;
          end else if (m_rpm >= 128) begin
            m_state = S_BLOWN; m_rpm = 0; m_gear = 0;
          end else begin
            m_state = S_RUN; m_gear--; m_rpm = m_rpm * 2;
          end
        end
      end else begin
        m_rpm = 0; m_gear = 0;
      end
    end
    m_dpos = dpos_new;
  endtask

  task automatic check_model(input string tag);
    expect_val({tag, "/rpm"}, 32'(rpm), m_rpm);
    expect_val({tag, "/gear"}, 32'(gear), m_gear);
    expect_val({tag, "/d_position"}, 32'(d_position), m_dpos);
    expect_val({tag, "/shifting"}, 32'(shifting), int'(m_state == S_SHIFT));
    expect_val({tag, "/blown"}, 32'(blown), int'(m_state == S_BLOWN));
`ifdef PERFECT_SHIFT_EN
    expect_val({tag, "/perfect"}, 32'(perfect), int'(m_perfect));
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  // Four clocks; the tick lands on the first one, a button press on the second.
  task automatic group(input bit up, input bit dn, input string tag);
    cycle(tag);
    gear_up = up; gear_down = dn;
    cycle(tag);
    gear_up = 0; gear_down = 0;
    cycle(tag);
    cycle(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) group(0, 0, tag);
  endtask

  initial begin
    int guard;
    rst = 0; race_active = 0; gas = 0; gear_up = 0; gear_down = 0;
    model_reset();
    #1 rst = 1;
    repeat (3) @(negedge clk);
    expect_val("reset/rpm", 32'(rpm), 0);
    expect_val("reset/gear", 32'(gear), 0);
    expect_val("reset/d_position", 32'(d_position), 0);
    expect_val("reset/shifting", 32'(shifting), 0);
    expect_val("reset/blown", 32'(blown), 0);
    rst = 0;
    model_reset();
    for (int i = 0; i < TD - 1; i++) cycle("pre");

    // Idle with race off
    ticks(5, "idle");
    expect_val("idle5/rpm", 32'(rpm), 16);
    expect_val("idle5/gear", 32'(gear), 0);
    expect_val("idle5/d_position", 32'(d_position), 0);

    // Launch and rev in gear 1, upshift request on the 20th tick's window
    race_active = 1; gas = 1;
    ticks(19, "launch");
    group(1, 0, "launch_up");
    expect_val("launch/rpm", 32'(rpm), 96);
    expect_val("launch/gear", 32'(gear), 1);
    expect_val("launch/d_position", 32'(d_position), 3);
    gas = 0;
    ticks(1, "shift_in");
    expect_val("shift_in/shifting", 32'(shifting), 1);
    expect_val("shift_in/rpm", 32'(rpm), 96);
    ticks(9, "shift_mid");
    expect_val("shift_mid/shifting", 32'(shifting), 1);
    ticks(1, "shift_out");
    expect_val("shift_out/gear", 32'(gear), 2);
    expect_val("shift_out/rpm", 32'(rpm), 38);
    expect_val("shift_out/shifting", 32'(shifting), 0);

    // Simultaneous up+down ignored
    group(1, 1, "both");
    ticks(1, "both_after");
    expect_val("both/shifting", 32'(shifting), 0);
    expect_val("both/gear", 32'(gear), 2);

    // Climb to gear 5, then upshift at the limit is ignored
    gas = 1;
    for (int g = 0; g < 3; g++) begin
      group(1, 0, "climb_req");
      ticks(11, "climb");
    end
    expect_val("climb/gear", 32'(gear), 5);
    group(1, 0, "top_req");
    ticks(1, "top_after");
    expect_val("top/shifting", 32'(shifting), 0);
    expect_val("top/gear", 32'(gear), 5);

    // Sustained redline blows the engine
    guard = 0;
    while (m_rpm != 255 && guard < 100) begin
      group(0, 0, "to_redline");
      guard++;
    end
    expect_val("redline/reach", 32'(rpm), 255);
    ticks(48, "redline");
    expect_val("redline49/blown", 32'(blown), 0);
    ticks(1, "redline50");
    expect_val("redline50/blown", 32'(blown), 1);
    expect_val("redline50/rpm", 32'(rpm), 0);
    expect_val("redline50/d_position", 32'(d_position), 0);
    race_active = 0; gas = 0;
    ticks(1, "recover");
    expect_val("recover/blown", 32'(blown), 0);
    expect_val("recover/gear", 32'(gear), 0);
    expect_val("recover/rpm", 32'(rpm), 16);

    // Upshift entered at rpm 220 (perfect window when enabled)
    race_active = 1; gas = 1;
    ticks(50, "perf_rev");
    group(1, 0, "perf_req");
    expect_val("perf_req/rpm", 32'(rpm), 220);
    gas = 0;
    ticks(10, "perf_shift");
    cycle("perf_exit");
    expect_val("perf_exit/gear", 32'(gear), 2);
    expect_val("perf_exit/rpm", 32'(rpm), PERFECT_BUILD ? 132 : 100);
`ifdef PERFECT_SHIFT_EN
    expect_val("perf_exit/perfect", 32'(perfect), 1);
`endif
    cycle("perf_after");
`ifdef PERFECT_SHIFT_EN
    expect_val("perf_after/perfect", 32'(perfect), 0);
`endif
    cycle("perf_after");
    cycle("perf_after");

    // Downshift from high rpm blows the engine
    gas = 1;
    ticks(30, "dn_rev");
    group(0, 1, "dn_req");
    ticks(11, "dn_shift");
    expect_val("dn_blow/blown", 32'(blown), 1);
    expect_val("dn_blow/gear", 32'(gear), 0);

    // Downshift in gear 1 is ignored
    race_active = 0; gas = 0;
    ticks(1, "g1_idle");
    race_active = 1;
    ticks(1, "g1_run");
    group(0, 1, "g1_req");
    ticks(1, "g1_after");
    expect_val("g1/shifting", 32'(shifting), 0);
    expect_val("g1/gear", 32'(gear), 1);

    // Random stimulus against the model, with one asynchronous reset midway
    for (int i = 0; i < 1600; i++) begin
      race_active = ($urandom_range(0, 99) < 95);
      gas         = ($urandom_range(0, 3) != 0);
      gear_up     = ($urandom_range(0, 11) == 0);
      gear_down   = ($urandom_range(0, 13) == 0);
      cycle("rand");
      if (i == 800) begin
        #2 rst = 1;
        #1;
        expect_val("async_rst/rpm", 32'(rpm), 0);
        expect_val("async_rst/gear", 32'(gear), 0);
        expect_val("async_rst/d_position", 32'(d_position), 0);
        expect_val("async_rst/shifting", 32'(shifting), 0);
        expect_val("async_rst/blown", 32'(blown), 0);
        @(negedge clk);
        rst = 0;
        model_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
